// File: rtl/ldmx_daq_rdo_pkg.sv
// Shared definitions for the LDMX DAQ readout sequencer: FSM states, register-bus
// addresses, status-word field positions and the page-size decode.
package ldmx_daq_rdo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_GAP,
    S_HDR,
    S_DATA,
    S_ADVANCE
  } rdo_state_e;

  localparam logic [11:0] STS1_ADDR    = 12'h041;
  localparam logic [11:0] CMD1_ADDR    = 12'h001;
  localparam logic [11:0] DATA_BASE    = 12'h800;
  localparam logic [31:0] ADVANCE_WORD = 32'h0000_0002;

  localparam int STS_EMPTY_BIT = 0;
  localparam int STS_LEN_LSB   = 16;
  localparam int STS_LEN_MSB   = 26;

  // Maximum number of words a single event may occupy for a given page-size code.
  function automatic logic [11:0] page_words(input logic [1:0] page_size);
    case (page_size)
      2'd0:    return 12'd512;
      2'd1:    return 12'd1024;
      default: return 12'd2048;
    endcase
  endfunction

endpackage

// File: rtl/daq_bus_master.sv
// Single-transaction register-bus engine. Holds strobe/address/data until the
// matching ack, samples read data on the ack cycle, and gives up after TIMEOUT
// cycles without an ack. Accepts a new request only while both strobes are low,
// so every transaction is followed by at least one idle bus cycle.
module daq_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        axi_clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        m_rstr,
  output logic [11:0] m_raddr,
  input  logic        m_rack,
  input  logic [31:0] m_dout,
  output logic        m_wstr,
  output logic [11:0] m_waddr,
  output logic [31:0] m_din,
  input  logic        m_wack,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            active;
  logic            ack;

  assign active = m_rstr | m_wstr;
  assign ack    = (m_rstr & m_rack) | (m_wstr & m_wack);

  // Launch, hold and retire one bus transaction at a time.
  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rstr   <= 1'b0;
      m_raddr  <= '0;
      m_wstr   <= 1'b0;
      m_waddr  <= '0;
      m_din    <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (active) begin
        if (ack) begin
          m_rstr <= 1'b0;
          m_wstr <= 1'b0;
          done   <= 1'b1;
          if (m_rstr) rdata <= m_dout;
        end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
          m_rstr  <= 1'b0;
          m_wstr  <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (req) begin
        wait_cnt <= '0;
        if (req_we) begin
          m_wstr  <= 1'b1;
          m_waddr <= req_addr;
          m_din   <= req_wdata;
        end else begin
          m_rstr  <= 1'b1;
          m_raddr <= req_addr;
        end
      end
    end
  end

endmodule

// File: rtl/ldmx_daq_readout_ctrl.sv
// LDMX DAQ readout sequencer: polls the DAQ status register, streams each event's
// page words onto a valid/ready stream with sof/eof, then writes the advance
// command to release the page.
// Optional feature: define READOUT_HEADER_EN to precede every event with one
// header word {4'hA, 5'h0, len[10:0], evt_count[11:0]} that carries tsof.
module ldmx_daq_readout_ctrl
  import ldmx_daq_rdo_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic             axi_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       page_size,
  output logic             m_rstr,
  output logic [11:0]      m_raddr,
  input  logic             m_rack,
  input  logic [31:0]      m_dout,
  output logic             m_wstr,
  output logic [11:0]      m_waddr,
  output logic [31:0]      m_din,
  input  logic             m_wack,
  output logic [31:0]      tdata,
  output logic             tvalid,
  output logic             tsof,
  output logic             teof,
  input  logic             tready,
  output logic [CNT_W-1:0] evt_count,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_len,
  input  logic             err_clr
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  rdo_state_e       state;
  logic             pend;
  logic             req;
  logic             req_we;
  logic [11:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             bm_done;
  logic             bm_timeout;
  logic [31:0]      bm_rdata;
  logic [11:0]      evt_len;
  logic [11:0]      idx;
  logic             sof_pend;
  logic [GAP_W-1:0] gap_cnt;
  logic [10:0]      sts_len;
  logic             len_over;
  logic [11:0]      clip_len;
  logic             slot_free;
`ifdef READOUT_HEADER_EN
  logic [10:0]      hdr_len;
`endif

  daq_bus_master #(.TIMEOUT(TIMEOUT)) u_bus (
    .axi_clk   (axi_clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .m_rstr    (m_rstr),
    .m_raddr   (m_raddr),
    .m_rack    (m_rack),
    .m_dout    (m_dout),
    .m_wstr    (m_wstr),
    .m_waddr   (m_waddr),
    .m_din     (m_din),
    .m_wack    (m_wack),
    .done      (bm_done),
    .rdata     (bm_rdata),
    .timeout   (bm_timeout)
  );

  assign busy = (state != S_IDLE);

  // Decode the status length, clip it to the page, and flag a free output slot.
  always_comb begin
    sts_len   = bm_rdata[STS_LEN_MSB:STS_LEN_LSB];
    len_over  = ({1'b0, sts_len} > page_words(page_size));
    clip_len  = len_over ? page_words(page_size) : {1'b0, sts_len};
    slot_free = !tvalid || tready;
  end

  // Readout sequencer: bus requests, output word register and sticky errors.
  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pend        <= 1'b0;
      req         <= 1'b0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      evt_len     <= '0;
      idx         <= '0;
      sof_pend    <= 1'b0;
      gap_cnt     <= '0;
      tdata       <= '0;
      tvalid      <= 1'b0;
      tsof        <= 1'b0;
      teof        <= 1'b0;
      evt_count   <= '0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_len     <= '0;
`endif
    end else begin
      req <= 1'b0;
      if (tvalid && tready) begin
        tvalid <= 1'b0;
        tsof   <= 1'b0;
        teof   <= 1'b0;
      end
      // Clear first so that an error raised in the same cycle stays set.
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_len     <= 1'b0;
      end
      if (bm_timeout) begin
        err_timeout <= 1'b1;
        pend        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable) state <= S_POLL;
          end
          S_POLL: begin
            if (!pend) begin
              req      <= 1'b1;
              req_we   <= 1'b0;
              req_addr <= STS1_ADDR;
              pend     <= 1'b1;
            end else if (bm_done) begin
              pend <= 1'b0;
              if (bm_rdata[STS_EMPTY_BIT]) begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                if (len_over) err_len <= 1'b1;
                evt_len  <= clip_len;
                idx      <= '0;
                sof_pend <= 1'b1;
`ifdef READOUT_HEADER_EN
                hdr_len  <= sts_len;
                state    <= S_HDR;
`else
                state    <= S_DATA;
`endif
              end
            end
          end
          S_GAP: begin
            if (!enable)                             state   <= S_IDLE;
            else if (gap_cnt == GAP_W'(POLL_GAP - 1)) state   <= S_POLL;
            else                                     gap_cnt <= gap_cnt + 1'b1;
          end
`ifdef READOUT_HEADER_EN
          S_HDR: begin
            if (slot_free) begin
              tdata    <= {4'hA, 5'h0, hdr_len, evt_count[11:0]};
              tvalid   <= 1'b1;
              tsof     <= 1'b1;
              teof     <= (evt_len == 12'd0);
              sof_pend <= 1'b0;
              state    <= S_DATA;
            end
          end
`endif
          S_DATA: begin
            // A read is launched only when its data is sure to find the register empty.
            if (!pend) begin
              if (idx == evt_len) begin
                state <= S_ADVANCE;
              end else if (slot_free) begin
                req      <= 1'b1;
                req_we   <= 1'b0;
                req_addr <= DATA_BASE | {1'b0, idx[10:0]};
                pend     <= 1'b1;
              end
            end else if (bm_done) begin
              pend     <= 1'b0;
              tdata    <= bm_rdata;
              tvalid   <= 1'b1;
              tsof     <= sof_pend;
              teof     <= (idx + 12'd1 == evt_len);
              sof_pend <= 1'b0;
              idx      <= idx + 12'd1;
            end
          end
          S_ADVANCE: begin
            if (!pend) begin
              req       <= 1'b1;
              req_we    <= 1'b1;
              req_addr  <= CMD1_ADDR;
              req_wdata <= ADVANCE_WORD;
              pend      <= 1'b1;
            end else if (bm_done) begin
              pend      <= 1'b0;
              evt_count <= evt_count + 1'b1;
              state     <= enable ? S_POLL : S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
